// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bank: command encoding, frame
// state encoding and frame length derivation.
package spi_pkg;

  // Leading frame bit: 1 selects a write, 0 selects a read.
  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_e;

  // Position within the current frame.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_COMMIT
  } frame_state_e;

  // One R/W bit, then the address field, then the data field.
  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus a history flop for edge detection.
// Edges are reported only once the history flop holds a real sample, so the
// reset values never produce a false edge after reset is released.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic       meta;
  logic       sync;
  logic       hist;
  logic [1:0] prime;

  // Synchronizer chain, history flop and post-reset priming counter.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every flop here uses <= so all stages sample the pre-edge values
    // together; a blocking = would collapse the chain into a single stage.
    if (!rst) begin
      meta  <= RESET_VAL;
      sync  <= RESET_VAL;
      hist  <= RESET_VAL;
      prime <= 2'd0;
    end else begin
      meta <= d;
      sync <= meta;
      hist <= sync;
      if (prime != 2'd3) prime <= prime + 2'd1;
    end
  end

  assign q    = sync;
  assign rise = (prime == 2'd3) &  sync & ~hist;
  assign fall = (prime == 2'd3) & ~sync &  hist;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI (mode 0) peripheral exposing NUM_REGS registers of DATA_W bits.
// Everything runs on clk; cs, sclk and copi are oversampled.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cs,
  input  logic                       sclk,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [CNT_W-1:0]  CNT_ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  CNT_FULL      = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_SAT       = CNT_W'(FRAME_LEN + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W    = (ADDR_W + 1)'(NUM_REGS);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic unused_edges;

  frame_state_e state, state_nxt;
  logic armed, sample, commit_go, rd_load;

  logic [CNT_W-1:0]  bit_cnt;
  rw_e               rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              addr_in_range;
  logic              frame_ok;
  logic [IDX_W-1:0]  reg_idx;

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] out_shift;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs), .q(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .d(copi), .q(copi_lvl), .rise(copi_rise), .fall(copi_fall)
  );

  // Only the copi level and the sclk edges matter to the frame logic.
  assign unused_edges = ^{sclk_lvl, copi_rise, copi_fall};

  assign addr_in_range = ({1'b0, addr_q} < NUM_REGS_W);
  assign frame_ok      = (rw_q == RW_WRITE) && (bit_cnt == CNT_FULL) && addr_in_range;
  assign reg_idx       = addr_q[IDX_W-1:0];
  assign rd_word       = addr_in_range ? mem[reg_idx] : '0;

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next frame state; a cs edge always wins over an sclk edge.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
      ST_CMD, ST_ADDR, ST_DATA: begin
        if (cs_rise)      state_nxt = frame_ok ? ST_COMMIT : ST_IDLE;
        else if (cs_fall) state_nxt = ST_CMD;
        else if (sample) begin
          if (state == ST_CMD) state_nxt = ST_ADDR;
          else if (state == ST_ADDR && bit_cnt == CNT_ADDR_LAST) state_nxt = ST_DATA;
        end
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Frame-state decoded controls.
  always_comb begin
    armed     = (state inside {ST_CMD, ST_ADDR, ST_DATA});
    sample    = armed && sclk_rise && !cs_lvl && !cs_rise;
    commit_go = armed && cs_rise && frame_ok;
    rd_load   = (state == ST_DATA) && sclk_fall && !cs_lvl && (rw_q == RW_READ) && !cipo_oe;
    wr_strobe = (state == ST_COMMIT);
  end

  // Bit counter and input shifters, split per frame field.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (cs_fall) begin
      bit_cnt <= '0;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (sample) begin
      if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
      case (state)
        ST_CMD:  rw_q   <= rw_e'(copi_lvl);
        ST_ADDR: addr_q <= (addr_q << 1) | ADDR_W'(copi_lvl);
        ST_DATA: if (bit_cnt < CNT_FULL) data_q <= (data_q << 1) | DATA_W'(copi_lvl);
        default: ;
      endcase
    end
  end

  // Register file and last-write address; written on the edge entering commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the bank is a small flop array, so each entry is reset explicitly.
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      wr_addr <= '0;
    end else if (commit_go) begin
      mem[reg_idx] <= data_q;
      wr_addr      <= addr_q;
    end
  end

  // Read shifter: load after the address field, shift on each later sclk fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_shift <= '0;
      cipo_oe   <= 1'b0;
    end else if (cs_rise || cs_fall) begin
      out_shift <= '0;
      cipo_oe   <= 1'b0;
    end else if (rd_load) begin
      out_shift <= rd_word;
      cipo_oe   <= 1'b1;
    end else if (cipo_oe && sclk_fall) begin
      out_shift <= out_shift << 1;
    end
  end

  assign cipo = cipo_oe & out_shift[DATA_W-1];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench: two instances (default and 4/16/16 parameters) share
// one SPI bus; each frame is judged by a per-instance reference model.
module tb_spi_reg_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cs = 1'b1, sclk = 1'b0, copi = 1'b0;

  logic         cipo0, oe0, wr_strobe0;
  logic [39:0]  regs0;
  logic [6:0]   wr_addr0;
  logic         cipo1, oe1, wr_strobe1;
  logic [255:0] regs1;
  logic [3:0]   wr_addr1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0]  m0 [5];
  logic [15:0] m1 [16];
  int          exp_strobes0 = 0, exp_strobes1 = 0;
  logic [6:0]  exp_addr0 = '0;
  logic [3:0]  exp_addr1 = '0;

  // Observed activity.
  int          strobes0 = 0, strobes1 = 0;
  logic [6:0]  seen_addr0 = '0;
  logic [3:0]  seen_addr1 = '0;
  logic [31:0] rx0, rx1;
  int          oe0_cnt, oe1_cnt;

  always #5 clk = ~clk;

  spi_reg_bank u_dut0 (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .copi(copi),
    .cipo(cipo0), .cipo_oe(oe0), .regs(regs0),
    .wr_strobe(wr_strobe0), .wr_addr(wr_addr0)
  );

  spi_reg_bank #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(16)) u_dut1 (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .copi(copi),
    .cipo(cipo1), .cipo_oe(oe1), .regs(regs1),
    .wr_strobe(wr_strobe1), .wr_addr(wr_addr1)
  );

  // Count strobe cycles and capture the address shown with each one.
  always @(negedge clk) begin
    if (wr_strobe0 === 1'b1) begin strobes0++; seen_addr0 = wr_addr0; end
    if (wr_strobe1 === 1'b1) begin strobes1++; seen_addr1 = wr_addr1; end
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 5; i++)  m0[i] = '0;
    for (int i = 0; i < 16; i++) m1[i] = '0;
  endtask

  // A frame writes only if it is exactly the instance's length, starts with 1
  // and addresses an implemented register.
  task automatic model_frame(input int nbits, input logic [31:0] fr);
    int a;
    if (nbits == 16 && fr[15]) begin
      a = int'((fr >> 8) & 32'h7f);
      if (a < 5) begin m0[a] = fr[7:0]; exp_strobes0++; exp_addr0 = 7'(a); end
    end
    if (nbits == 21 && fr[20]) begin
      a = int'((fr >> 16) & 32'hf);
      m1[a] = fr[15:0]; exp_strobes1++; exp_addr1 = 4'(a);
    end
  endtask

  function automatic logic [7:0] model_read0(input int a);
    return (a < 5) ? m0[a] : 8'h00;
  endfunction

  function automatic logic [39:0] flat0();
    logic [39:0] f;
    for (int i = 0; i < 5; i++) f[i*8 +: 8] = m0[i];
    return f;
  endfunction

  function automatic logic [255:0] flat1();
    logic [255:0] f;
    for (int i = 0; i < 16; i++) f[i*16 +: 16] = m1[i];
    return f;
  endfunction

  function automatic logic [31:0] frame0(input bit w, input int a, input logic [7:0] d);
    return {16'b0, w, 7'(a), d};
  endfunction

  function automatic logic [31:0] frame1(input bit w, input int a, input logic [15:0] d);
    return {11'b0, w, 4'(a), d};
  endfunction

  // ---------------- bus driver ----------------
  task automatic cs_drop();
    @(negedge clk); cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_raise();
    repeat (4) @(negedge clk); cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Shift out bits nbits-1..0 of fr; cipo is captured just before each rise.
  task automatic send_bits(input int nbits, input logic [31:0] fr);
    rx0 = '0; rx1 = '0; oe0_cnt = 0; oe1_cnt = 0;
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = fr[i];
      repeat (3) @(negedge clk);
      rx0 = {rx0[30:0], cipo0};
      rx1 = {rx1[30:0], cipo1};
      if (oe0 === 1'b1) oe0_cnt++;
      if (oe1 === 1'b1) oe1_cnt++;
      sclk = 1'b1;
      repeat (6) @(negedge clk);
      sclk = 1'b0;
      repeat (3) @(negedge clk);
    end
    copi = 1'b0;
  endtask

  task automatic do_frame(input int nbits, input logic [31:0] fr);
    cs_drop();
    send_bits(nbits, fr);
    cs_raise();
    model_frame(nbits, fr);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; cs = 1'b1; sclk = 1'b0; copi = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (regs0 !== 40'h0) begin n_fail++; $display("FAIL reset_regs0: got %h expected 0", regs0); end
    n_checks++;
    if (regs1 !== 256'h0) begin n_fail++; $display("FAIL reset_regs1: got %h expected 0", regs1); end
    n_checks++;
    if ({wr_strobe0, wr_addr0, cipo0, oe0} !== 10'h0) begin
      n_fail++; $display("FAIL reset_outs0: strobe %b addr %h cipo %b oe %b expected all 0", wr_strobe0, wr_addr0, cipo0, oe0);
    end
    n_checks++;
    if ({wr_strobe1, wr_addr1, cipo1, oe1} !== 7'h0) begin
      n_fail++; $display("FAIL reset_outs1: strobe %b addr %h cipo %b oe %b expected all 0", wr_strobe1, wr_addr1, cipo1, oe1);
    end
  endtask

  task automatic test_write_read();
    do_frame(16, frame0(1'b1, 3, 8'hA5));
    n_checks++;
    if (regs0[31:24] !== 8'hA5) begin n_fail++; $display("FAIL wr_reg3: got %h expected a5", regs0[31:24]); end
    n_checks++;
    if (regs0 !== flat0()) begin n_fail++; $display("FAIL wr_regs0: got %h expected %h", regs0, flat0()); end
    n_checks++;
    if (strobes0 !== 1) begin n_fail++; $display("FAIL wr_strobe_cnt: got %0d expected 1", strobes0); end
    n_checks++;
    if (seen_addr0 !== 7'd3) begin n_fail++; $display("FAIL wr_addr: got %h expected 3", seen_addr0); end

    do_frame(16, frame0(1'b0, 3, 8'h00));
    n_checks++;
    if (rx0[7:0] !== 8'hA5) begin n_fail++; $display("FAIL rd_data3: got %h expected a5", rx0[7:0]); end
    n_checks++;
    if (oe0_cnt !== 8) begin n_fail++; $display("FAIL rd_oe_bits: got %0d expected 8", oe0_cnt); end
    n_checks++;
    if (regs0 !== flat0() || strobes0 !== exp_strobes0) begin
      n_fail++; $display("FAIL rd_side_effect: regs %h strobes %0d expected %h %0d", regs0, strobes0, flat0(), exp_strobes0);
    end
    n_checks++;
    if ({oe0, cipo0} !== 2'b00) begin n_fail++; $display("FAIL rd_oe_release: oe %b cipo %b expected 0 0", oe0, cipo0); end
  endtask

  task automatic test_out_of_range();
    do_frame(16, frame0(1'b1, 7, 8'hFF));
    n_checks++;
    if (regs0 !== flat0()) begin n_fail++; $display("FAIL oor_regs: got %h expected %h", regs0, flat0()); end
    n_checks++;
    if (strobes0 !== exp_strobes0) begin n_fail++; $display("FAIL oor_strobe: got %0d expected %0d", strobes0, exp_strobes0); end
    do_frame(16, frame0(1'b0, 7, 8'h00));
    n_checks++;
    if (rx0[7:0] !== 8'h00 || oe0_cnt !== 8) begin
      n_fail++; $display("FAIL oor_read: data %h oe %0d expected 00 8", rx0[7:0], oe0_cnt);
    end
  endtask

  task automatic test_short_long();
    logic [31:0] fr;
    fr = frame0(1'b1, 3, 8'h3C);
    do_frame(10, fr >> 6);
    fr = frame0(1'b1, 1, 8'h5A);
    do_frame(17, (fr << 1) | 32'h1);
    n_checks++;
    if (regs0 !== flat0() || strobes0 !== exp_strobes0) begin
      n_fail++; $display("FAIL short_long: regs %h strobes %0d expected %h %0d", regs0, strobes0, flat0(), exp_strobes0);
    end
    // Sixteenth sclk rise arrives together with cs rising: it must not count.
    fr = frame0(1'b1, 2, 8'h77);
    cs_drop();
    send_bits(15, fr >> 1);
    copi = fr[0];
    repeat (3) @(negedge clk);
    sclk = 1'b1; cs = 1'b1;
    repeat (6) @(negedge clk);
    sclk = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (regs0 !== flat0() || strobes0 !== exp_strobes0) begin
      n_fail++; $display("FAIL cs_sclk_same: regs %h strobes %0d expected %h %0d", regs0, strobes0, flat0(), exp_strobes0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s0, s1;
    logic [31:0] fr;
    do_frame(16, frame0(1'b1, 0, 8'h42));
    n_checks++;
    if (regs0[7:0] !== 8'h42) begin n_fail++; $display("FAIL pre_rst_wr: got %h expected 42", regs0[7:0]); end
    fr = frame0(1'b1, 0, 8'h99);
    cs_drop();
    send_bits(6, fr >> 10);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    s0 = strobes0; s1 = strobes1;
    send_bits(16, fr);
    cs_raise();
    n_checks++;
    if (regs0 !== 40'h0 || regs1 !== 256'h0) begin
      n_fail++; $display("FAIL rst_mid_regs: regs0 %h regs1 %h expected 0", regs0, regs1);
    end
    n_checks++;
    if (strobes0 !== s0 || strobes1 !== s1) begin
      n_fail++; $display("FAIL rst_mid_strobe: got %0d %0d expected %0d %0d", strobes0, strobes1, s0, s1);
    end
    exp_strobes0 = s0; exp_strobes1 = s1;
    do_frame(16, fr);
    n_checks++;
    if (regs0 !== flat0() || strobes0 !== exp_strobes0) begin
      n_fail++; $display("FAIL rst_recover: regs %h strobes %0d expected %h %0d", regs0, strobes0, flat0(), exp_strobes0);
    end
  endtask

  task automatic test_wide();
    do_frame(21, frame1(1'b1, 15, 16'hBEEF));
    n_checks++;
    if (regs1[255:240] !== 16'hBEEF) begin n_fail++; $display("FAIL wide_wr: got %h expected beef", regs1[255:240]); end
    n_checks++;
    if (strobes1 !== exp_strobes1 || seen_addr1 !== 4'd15) begin
      n_fail++; $display("FAIL wide_strobe: cnt %0d addr %h expected %0d f", strobes1, seen_addr1, exp_strobes1);
    end
    n_checks++;
    if (regs0 !== flat0()) begin n_fail++; $display("FAIL wide_regs0: got %h expected %h", regs0, flat0()); end
    do_frame(21, frame1(1'b0, 15, 16'h0000));
    n_checks++;
    if (rx1[15:0] !== 16'hBEEF || oe1_cnt !== 16) begin
      n_fail++; $display("FAIL wide_rd: data %h oe %0d expected beef 16", rx1[15:0], oe1_cnt);
    end
  endtask

  task automatic test_random();
    int kind, nbits, a;
    logic [31:0] fr;
    logic [7:0]  e0;
    logic [15:0] e1;
    for (int it = 0; it < 24; it++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0, 1: begin
          nbits = 16;
          fr = frame0(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 8'($urandom));
        end
        2, 3: begin
          nbits = 21;
          fr = frame1(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 16'($urandom));
        end
        4: begin
          nbits = int'($urandom_range(1, 15));
          fr = $urandom & ((32'h1 << nbits) - 32'h1);
        end
        default: begin
          nbits = int'($urandom_range(17, 31));
          fr = $urandom & ((32'h1 << nbits) - 32'h1);
        end
      endcase
      a  = int'((fr >> 8) & 32'h7f);
      e0 = model_read0(a);
      e1 = m1[int'((fr >> 16) & 32'hf)];
      do_frame(nbits, fr);
      n_checks++;
      if (regs0 !== flat0() || strobes0 !== exp_strobes0) begin
        n_fail++; $display("FAIL rand%0d_dut0: regs %h strobes %0d expected %h %0d", it, regs0, strobes0, flat0(), exp_strobes0);
      end
      n_checks++;
      if (regs1 !== flat1() || strobes1 !== exp_strobes1) begin
        n_fail++; $display("FAIL rand%0d_dut1: regs %h strobes %0d expected %h %0d", it, regs1, strobes1, flat1(), exp_strobes1);
      end
      if (exp_strobes0 > 0) begin
        n_checks++;
        if (seen_addr0 !== exp_addr0) begin n_fail++; $display("FAIL rand%0d_wr_addr0: got %h expected %h", it, seen_addr0, exp_addr0); end
      end
      if (nbits == 16 && !fr[15]) begin
        n_checks++;
        if (rx0[7:0] !== e0 || oe0_cnt !== 8) begin
          n_fail++; $display("FAIL rand%0d_rd0: data %h oe %0d expected %h 8", it, rx0[7:0], oe0_cnt, e0);
        end
      end
      if (nbits == 21 && !fr[20]) begin
        n_checks++;
        if (rx1[15:0] !== e1 || oe1_cnt !== 16) begin
          n_fail++; $display("FAIL rand%0d_rd1: data %h oe %0d expected %h 16", it, rx1[15:0], oe1_cnt, e1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_short_long();
    test_reset_mid_frame();
    test_wide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
